// File: rtl/note_pkg.sv
// Shared definitions for the note sequencer.
// Holds the geometry constants (memory address/data widths, lane count,
// window depth, end-of-song bit), the FSM state encoding, and a helper
// that maps the song_len input to an effective word count.
package note_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int LANES   = 4;
    localparam int DEPTH   = 8;
    localparam int END_BIT = 31;
    localparam int DCNT_W  = $clog2(DEPTH) + 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_READY = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // A length of zero means "the whole memory".
    function automatic logic [ADDR_W:0] eff_len(input logic [ADDR_W:0] len);
        return (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : len;
    endfunction

endpackage

// File: rtl/note_window.sv
// Scrolling window of lane notes: DEPTH rows of LANES bits.
// Row 0 (bits [LANES-1:0]) is the newest row; a shift moves every row one
// position toward row DEPTH-1 and loads din into row 0.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : synchronous clear of all rows (wins over shift)
//   shift      : advance the window by one row
//   din        : lane bits loaded into row 0 on shift
//   rows       : packed window, row r = rows[r*LANES +: LANES]
module note_window
    import note_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [LANES-1:0]       din,
    output logic [LANES*DEPTH-1:0] rows
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows <= '0;
        end else if (clear) begin
            rows <= '0;
        end else if (shift) begin
            rows <= {rows[LANES*(DEPTH-1)-1:0], din};
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song sequencer: walks a note memory one word per tempo tick, prefetching
// the next word so that a tick in READY is applied on that very edge.
// After the last word it shifts DEPTH empty rows through the window and
// stops in DONE.
// Handshake: mem_rd is a one-cycle read strobe at mem_addr; the memory
// returns the word on mem_data during the following cycle, where WAIT
// captures it. There is no back-pressure.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   beat_tick   : one-cycle tempo pulse
//   start       : one-cycle (re)start from address 0, any state
//   pause       : level; ticks are ignored and pending is held while high
//   song_len    : words in song (0 = 64), sampled on start
//   mem_addr/mem_rd/mem_data : note memory read port
//   lane_rows   : scroll window, row 0 newest
//   hit_row     : oldest row (judgement row)
//   playing/done: status
//   beat_count  : song words shifted into the window since start
module note_sequencer
    import note_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat_tick,
    input  logic                   start,
    input  logic                   pause,
    input  logic [ADDR_W:0]        song_len,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic [LANES*DEPTH-1:0] lane_rows,
    output logic [LANES-1:0]       hit_row,
    output logic                   playing,
    output logic                   done,
    output logic [ADDR_W:0]        beat_count
);

    state_t              state;
    logic [ADDR_W:0]     len_q;
    logic [DATA_W-1:0]   next_word;
    logic                pending;
    logic                end_seen;
    logic [DCNT_W-1:0]   drain_cnt;

    logic                tick_in;
    logic                service;
    logic [ADDR_W:0]     next_addr;
    logic                last_word;
    logic                win_shift;
    logic [LANES-1:0]    win_din;
    logic                unused_bits;

    assign tick_in   = beat_tick & ~pause;
    // READY services either a fresh tick or one latched during the fetch.
    assign service   = ~pause & (beat_tick | pending);
    assign next_addr = {1'b0, mem_addr} + 1'b1;
    assign last_word = next_word[END_BIT] | (next_addr == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mem_addr   <= '0;
            len_q      <= '0;
            next_word  <= '0;
            pending    <= 1'b0;
            end_seen   <= 1'b0;
            drain_cnt  <= '0;
            beat_count <= '0;
        end else if (start) begin
            // Restart discards any tick arriving on the same edge.
            state      <= ST_FETCH;
            mem_addr   <= '0;
            len_q      <= eff_len(song_len);
            pending    <= 1'b0;
            end_seen   <= 1'b0;
            drain_cnt  <= '0;
            beat_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    if (tick_in) pending <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick_in) pending <= 1'b1;
                    next_word <= mem_data;
                    state     <= ST_READY;
                end
                ST_READY: begin
                    if (service) begin
                        pending    <= 1'b0;
                        beat_count <= beat_count + 1'b1;
                        if (last_word) begin
                            end_seen  <= 1'b1;
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tick_in) begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == DCNT_W'(DEPTH - 1)) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign win_shift = ~start & (((state == ST_READY) & service) |
                                 ((state == ST_DRAIN) & tick_in));
    assign win_din   = (state == ST_READY) ? next_word[LANES-1:0] : '0;

    note_window u_window (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .shift (win_shift),
        .din   (win_din),
        .rows  (lane_rows)
    );

    assign hit_row = lane_rows[LANES*(DEPTH-1) +: LANES];
    assign mem_rd  = (state == ST_FETCH);
    assign done    = (state == ST_DONE);
    assign playing = (state == ST_FETCH) | (state == ST_WAIT) |
                     (state == ST_READY) | (state == ST_DRAIN);

    // Word bits between the lanes and END_BIT carry no meaning here.
    assign unused_bits = ^{end_seen, next_word[END_BIT-1:LANES]};

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    import note_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   beat_tick;
    logic                   start;
    logic                   pause;
    logic [ADDR_W:0]        song_len;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic [LANES*DEPTH-1:0] lane_rows;
    logic [LANES-1:0]       hit_row;
    logic                   playing;
    logic                   done;
    logic [ADDR_W:0]        beat_count;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] mem [64];
    logic [LANES-1:0]  played [$];
    int                t_model;

    logic              track;
    logic [ADDR_W-1:0] max_addr;

    note_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .beat_tick  (beat_tick),
        .start      (start),
        .pause      (pause),
        .song_len   (song_len),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .lane_rows  (lane_rows),
        .hit_row    (hit_row),
        .playing    (playing),
        .done       (done),
        .beat_count (beat_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- note memory: one-cycle read latency ----------------
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (track && mem_rd && mem_addr > max_addr) max_addr = mem_addr;
    end

    // ---------------- reference model ----------------
    // The song as a list of lane values: words from 0 up to and including
    // the first END_BIT word, or until the length runs out.
    function automatic void build_song(input int len);
        int limit;
        limit = (len == 0) ? 64 : len;
        played.delete();
        for (int i = 0; i < limit; i++) begin
            played.push_back(mem[i][LANES-1:0]);
            if (mem[i][END_BIT]) break;
        end
    endfunction

    // Expected {lane_rows, hit_row, beat_count, done, playing} after t
    // accepted ticks: the stream is the song followed by empty rows, and
    // row r holds the element that entered r ticks ago.
    function automatic logic [44:0] exp_status(input int t);
        logic [31:0] rows;
        logic [3:0]  hit;
        int          n;
        int          idx;
        int          beats;
        logic        dn;
        n    = played.size();
        rows = '0;
        for (int r = 0; r < DEPTH; r++) begin
            idx = t - 1 - r;
            if (idx >= 0 && idx < n) rows[r*LANES +: LANES] = played[idx];
        end
        idx = t - DEPTH;
        hit = (idx >= 0 && idx < n) ? played[idx] : 4'h0;
        beats = (t < n) ? t : n;
        dn    = (t >= n + DEPTH);
        return {rows, hit, 7'(beats), dn, ~dn};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_start(input int len);
        @(negedge clk);
        start    = 1'b1;
        song_len = 7'(len);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        build_song(len);
        t_model = 0;
    endtask

    // Tick pulse from the current negedge; returns at a negedge gap cycles later.
    task automatic do_tick(input int gap, input logic with_pause);
        pause     = with_pause;
        beat_tick = 1'b1;
        @(negedge clk);
        beat_tick = 1'b0;
        pause     = 1'b0;
        repeat (gap - 1) @(negedge clk);
        if (!with_pause) t_model++;
    endtask

    function automatic void fill_plain(input int n);
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            mem[i][END_BIT] = 1'b0;
            if (i >= n) mem[i] = '0;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [44:0] got;
        reset = 1'b0;
        fill_plain(8);
        do_start(8);
        do_tick(10, 1'b0);
        do_tick(10, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        got = {lane_rows, hit_row, beat_count, done, playing};
        vectors++;
        if (got !== '0 || mem_rd !== 1'b0 || mem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h rd=%b addr=%h want all 0", got, mem_rd, mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_rd !== 1'b0 || dut.state !== ST_IDLE) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d rd=%b state=%0d want rd=0 state=IDLE", i, mem_rd, dut.state);
            end
        end
    endtask

    task automatic test_basic_song();
        logic [44:0] got;
        logic [44:0] want;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h4; mem[3] = 32'h8;
        do_start(4);
        for (int k = 1; k <= 12; k++) begin
            do_tick(10, 1'b0);
            got  = {lane_rows, hit_row, beat_count, done, playing};
            want = exp_status(t_model);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL basic_tick%0d got=%h want=%h", k, got, want);
            end
            if (k == 4) begin
                vectors++;
                if (lane_rows[15:0] !== 16'h1248) begin
                    miscompares++;
                    $display("FAIL basic_rows0_3 got=%h want=1248", lane_rows[15:0]);
                end
            end
            if (k >= 8 && k <= 11) begin
                vectors++;
                if (hit_row !== 4'(1 << (k - 8))) begin
                    miscompares++;
                    $display("FAIL basic_hit%0d got=%h want=%h", k, hit_row, 4'(1 << (k - 8)));
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || lane_rows !== '0 || beat_count !== 7'd4) begin
            miscompares++;
            $display("FAIL basic_done done=%b rows=%h beats=%0d want 1/0/4", done, lane_rows, beat_count);
        end
    endtask

    task automatic test_end_bit();
        logic [44:0] got;
        logic [44:0] want;
        fill_plain(64);
        mem[2][END_BIT] = 1'b1;
        max_addr = '0;
        track    = 1'b1;
        do_start(0);
        for (int k = 1; k <= 11; k++) begin
            do_tick(8, 1'b0);
            got  = {lane_rows, hit_row, beat_count, done, playing};
            want = exp_status(t_model);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL endbit_tick%0d got=%h want=%h", k, got, want);
            end
            if (k == 10) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL endbit_early_done got=%b want=0", done);
                end
            end
        end
        track = 1'b0;
        vectors++;
        if (done !== 1'b1 || beat_count !== 7'd3 || max_addr > 6'd2) begin
            miscompares++;
            $display("FAIL endbit_final done=%b beats=%0d max_addr=%0d want 1/3/<=2", done, beat_count, max_addr);
        end
    endtask

    task automatic test_pending();
        logic [44:0] got;
        logic [44:0] want;
        fill_plain(6);
        do_start(6);
        // Tick held three cycles: READY service, FETCH pending, WAIT dropped.
        beat_tick = 1'b1;
        repeat (3) @(negedge clk);
        beat_tick = 1'b0;
        vectors++;
        if (beat_count !== 7'd1) begin
            miscompares++;
            $display("FAIL pending_before_ready got=%0d want=1", beat_count);
        end
        @(negedge clk);
        vectors++;
        if (beat_count !== 7'd2 || lane_rows[7:0] !== {mem[0][3:0], mem[1][3:0]}) begin
            miscompares++;
            $display("FAIL pending_on_ready beats=%0d rows=%h want 2/%h", beat_count, lane_rows[7:0], {mem[0][3:0], mem[1][3:0]});
        end
        t_model = 2;
        repeat (6) @(negedge clk);
        got  = {lane_rows, hit_row, beat_count, done, playing};
        want = exp_status(t_model);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL pending_settled got=%h want=%h", got, want);
        end
    endtask

    task automatic test_pause();
        logic [44:0] got;
        logic [44:0] want;
        fill_plain(10);
        do_start(10);
        repeat (3) do_tick(7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_tick(7, (k < 3));
            got  = {lane_rows, hit_row, beat_count, done, playing};
            want = exp_status(t_model);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL pause_step%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_start_with_tick();
        logic [44:0] got;
        logic [44:0] want;
        fill_plain(12);
        do_start(12);
        repeat (5) do_tick(6, 1'b0);
        start     = 1'b1;
        beat_tick = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        beat_tick = 1'b0;
        vectors++;
        if (beat_count !== '0 || lane_rows !== '0 || mem_rd !== 1'b1 || mem_addr !== '0) begin
            miscompares++;
            $display("FAIL restart beats=%0d rows=%h rd=%b addr=%0d want 0/0/1/0", beat_count, lane_rows, mem_rd, mem_addr);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (beat_count !== '0) begin
            miscompares++;
            $display("FAIL restart_tick_dropped beats=%0d want=0", beat_count);
        end
        build_song(12);
        t_model = 0;
        do_tick(6, 1'b0);
        got  = {lane_rows, hit_row, beat_count, done, playing};
        want = exp_status(t_model);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL restart_first_tick got=%h want=%h", got, want);
        end
    endtask

    task automatic test_random_songs();
        logic [44:0] got;
        logic [44:0] want;
        int          len;
        int          nticks;
        logic        p;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] = $urandom;
                mem[i][END_BIT] = ($urandom_range(0, 15) == 0);
            end
            len = (it == 0) ? 64 : $urandom_range(0, 64);
            do_start(len);
            nticks = played.size() + DEPTH + 2;
            for (int k = 0; k < nticks; k++) begin
                p = ($urandom_range(0, 4) == 0);
                do_tick($urandom_range(4, 10), p);
                got  = {lane_rows, hit_row, beat_count, done, playing};
                want = exp_status(t_model);
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL random it=%0d tick=%0d got=%h want=%h", it, k, got, want);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        track       = 1'b0;
        max_addr    = '0;
        reset       = 1'b1;
        beat_tick   = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        song_len    = '0;
        t_model     = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_song();
        test_end_bit();
        test_pending();
        test_pause();
        test_start_with_tick();
        test_random_songs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
